// File: rtl/btn_req_frontend.sv
// btn_req_frontend: debounces the board's active-low start/config buttons,
// captures request fields from switch_array in configuration mode and issues
// one req/ack-handshaked bus-master request per start press in operation mode.
// Optional feature macro: BTN_REQ_AUTOINC_EN (advance req_addr by burst length
// after every completed transaction).
module btn_req_frontend #(
    parameter int DEBOUNCE_CYCLES = 10,
    parameter int ADDR_WIDTH      = 12,
    parameter int DATA_WIDTH      = 8,
    parameter int BURST_WIDTH     = 4
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   start_raw,
    input  logic                   cfg_raw,
    input  logic                   mode_switch,
    input  logic                   rw_switch,
    input  logic [11:0]            switch_array,
    input  logic                   m_busy,
    input  logic                   req_ack,
    output logic                   req,
    output logic                   req_rw,
    output logic [ADDR_WIDTH-1:0]  req_addr,
    output logic [DATA_WIDTH-1:0]  req_wdata,
    output logic [BURST_WIDTH-1:0] req_burst,
    output logic                   cfg_valid,
    output logic [7:0]             txn_count
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_FREE = 2'd1;
    localparam logic [1:0] S_REQ       = 2'd2;
    localparam logic [1:0] S_BUSY      = 2'd3;

    // Button index 0 = start, 1 = config.
    logic [1:0] w_raw;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_deb;
    logic [1:0] r_evt;

    logic [1:0]             r_state;
    logic                   r_req_rw;
    logic [ADDR_WIDTH-1:0]  r_req_addr;
    logic [DATA_WIDTH-1:0]  r_req_wdata;
    logic [BURST_WIDTH-1:0] r_req_burst;
    logic                   r_cfg_valid;
    logic                   r_cfg_step;
    logic [7:0]             r_txn_count;

    logic w_start_evt;
    logic w_cfg_evt;

    assign w_raw       = {cfg_raw, start_raw};
    assign w_start_evt = r_evt[0];
    assign w_cfg_evt   = r_evt[1];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_btn
            logic [CW-1:0] r_cnt;

            // Synchronize, debounce and emit a one-cycle pulse on each accepted press.
            always_ff @(posedge clock) begin
                if (!rst) begin
                    r_sync1[g] <= 1'b1;
                    r_sync2[g] <= 1'b1;
                    r_deb[g]   <= 1'b1;
                    r_evt[g]   <= 1'b0;
                    r_cnt      <= '0;
                end else if (enable) begin
                    r_sync1[g] <= w_raw[g];
                    r_sync2[g] <= r_sync1[g];
                    r_evt[g]   <= 1'b0;
                    if (r_sync2[g] == r_deb[g]) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        // This cycle is the DEBOUNCE_CYCLES-th mismatch: flip now.
                        r_cnt      <= '0;
                        r_deb[g]   <= r_sync2[g];
                        r_evt[g]   <= r_deb[g];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Request FSM plus configuration capture, transaction counter and address advance.
    always_ff @(posedge clock) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_req_rw    <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_burst <= '0;
            r_cfg_valid <= 1'b0;
            r_cfg_step  <= 1'b0;
            r_txn_count <= '0;
        end else if (enable) begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_evt && mode_switch && r_cfg_valid) begin
                        r_req_rw <= rw_switch;
                        r_state  <= m_busy ? S_WAIT_FREE : S_REQ;
                    end
                    if (w_cfg_evt && !mode_switch) begin
                        if (!r_cfg_step) begin
                            r_req_addr  <= switch_array[ADDR_WIDTH-1:0];
                            r_cfg_step  <= 1'b1;
                            r_cfg_valid <= 1'b0;
                        end else begin
                            r_req_wdata <= switch_array[DATA_WIDTH-1:0];
                            r_req_burst <= switch_array[11 -: BURST_WIDTH];
                            r_cfg_step  <= 1'b0;
                            r_cfg_valid <= 1'b1;
                        end
                    end
                end
                S_WAIT_FREE: begin
                    if (!m_busy) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (req_ack) begin
                        r_state <= S_BUSY;
                    end
                end
                default: begin
                    if (!m_busy) begin
                        r_state     <= S_IDLE;
                        r_txn_count <= r_txn_count + 8'd1;
`ifdef BTN_REQ_AUTOINC_EN
                        r_req_addr  <= r_req_addr + ADDR_WIDTH'(r_req_burst) + ADDR_WIDTH'(1);
`else
                        r_req_addr  <= r_req_addr;
`endif
                    end
                end
            endcase
        end
    end

    assign req       = (r_state == S_REQ);
    assign req_rw    = r_req_rw;
    assign req_addr  = r_req_addr;
    assign req_wdata = r_req_wdata;
    assign req_burst = r_req_burst;
    assign cfg_valid = r_cfg_valid;
    assign txn_count = r_txn_count;

endmodule

// File: tb/tb_btn_req_frontend.sv
// Self-checking bench for btn_req_frontend: directed scenarios plus randomized
// button/master activity compared against a transaction-level reference model.
module tb_btn_req_frontend;

    localparam int N  = 10;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int BW = 4;

    logic          clock = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b1;
    logic          start_raw = 1'b1;
    logic          cfg_raw = 1'b1;
    logic          mode_switch = 1'b0;
    logic          rw_switch = 1'b0;
    logic [11:0]   switch_array = '0;
    logic          m_busy = 1'b0;
    logic          req_ack = 1'b0;
    logic          req;
    logic          req_rw;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_burst;
    logic          cfg_valid;
    logic [7:0]    txn_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the architectural state.
    int m_addr  = 0;
    int m_wdata = 0;
    int m_burst = 0;
    int m_cfgv  = 0;
    int m_step  = 0;
    int m_txn   = 0;
    int m_rw    = 0;

    btn_req_frontend #(
        .DEBOUNCE_CYCLES (N),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .BURST_WIDTH     (BW)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .enable       (enable),
        .start_raw    (start_raw),
        .cfg_raw      (cfg_raw),
        .mode_switch  (mode_switch),
        .rw_switch    (rw_switch),
        .switch_array (switch_array),
        .m_busy       (m_busy),
        .req_ack      (req_ack),
        .req          (req),
        .req_rw       (req_rw),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_burst    (req_burst),
        .cfg_valid    (cfg_valid),
        .txn_count    (txn_count)
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_addr"},  int'(req_addr),  m_addr);
        check({tag, "_wdata"}, int'(req_wdata), m_wdata);
        check({tag, "_burst"}, int'(req_burst), m_burst);
        check({tag, "_cfgv"},  int'(cfg_valid), m_cfgv);
        check({tag, "_txn"},   int'(txn_count), m_txn);
    endtask

    task automatic model_reset();
        m_addr = 0; m_wdata = 0; m_burst = 0; m_cfgv = 0; m_step = 0; m_txn = 0; m_rw = 0;
    endtask

    task automatic set_btn(input bit is_cfg, input logic v);
        if (is_cfg) cfg_raw = v;
        else start_raw = v;
    endtask

    // Bounce nb times (segments shorter than N, seg=0 means random), then settle low.
    task automatic fall(input bit is_cfg, input int nb, input int seg);
        int len;
        for (int b = 0; b < nb; b++) begin
            len = (seg != 0) ? seg : int'($urandom_range(1, N - 2));
            set_btn(is_cfg, 1'b0);
            repeat (len) tick();
            len = (seg != 0) ? seg : int'($urandom_range(1, N - 2));
            set_btn(is_cfg, 1'b1);
            repeat (len) tick();
        end
        set_btn(is_cfg, 1'b0);
    endtask

    task automatic do_cfg(input logic [11:0] val, input bit mode);
        mode_switch  = mode;
        switch_array = val;
        fall(1'b1, int'($urandom_range(0, 3)), 0);
        repeat (N + 3) tick();
        switch_array = 12'($urandom);
        cfg_raw = 1'b1;
        repeat (N + 4) tick();
        if (!mode) begin
            if (m_step == 0) begin
                m_addr = int'(val) % (1 << AW);
                m_step = 1;
                m_cfgv = 0;
            end else begin
                m_wdata = int'(val) % (1 << DW);
                m_burst = int'(val) >> (12 - BW);
                m_step  = 0;
                m_cfgv  = 1;
            end
        end
        check_state(mode ? "cfg_ign" : "cfg");
    endtask

    task automatic do_start(input bit mode, input bit rw, input int hold, input bit gaps,
                            input int ack_dly, input int busy_len, input bit poke,
                            input int nb, input int seg);
        bit expect_req;
        bit seen;
        int lat;
        int guard;
        int hold_eff;
        expect_req  = mode && (m_cfgv != 0);
        hold_eff    = expect_req ? hold : 0;
        mode_switch = mode;
        rw_switch   = rw;
        m_busy      = (hold_eff > 0);
        fall(1'b0, nb, seg);
        if (!expect_req) begin
            seen = 1'b0;
            repeat (N + 10) begin
                tick();
                if (req) seen = 1'b1;
            end
            check("dropped_start_req", int'(seen), 0);
            start_raw = 1'b1;
            repeat (N + 4) tick();
            check_state("dropped_start");
            return;
        end
        lat = 0;
        guard = 0;
        while (!req && guard < 300) begin
            enable = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            guard++;
            if (enable) lat++;
            if (hold_eff > 0 && lat == N + 3 + hold_eff) m_busy = 1'b0;
        end
        enable = 1'b1;
        check("req_seen", int'(req), 1);
        check("req_latency", lat, (hold_eff > 0) ? (N + 4 + hold_eff) : (N + 3));
        m_rw = int'(rw);
        rw_switch = ~rw;
        check("req_rw", int'(req_rw), m_rw);
        check_state("req");
        repeat (ack_dly) tick();
        check("req_hold", int'(req), 1);
        check("req_rw_hold", int'(req_rw), m_rw);
        req_ack = 1'b1;
        m_busy  = 1'b1;
        tick();
        req_ack = 1'b0;
        check("req_drop", int'(req), 0);
        start_raw = 1'b1;
        repeat (N + 4) tick();
        if (poke) begin
            mode_switch  = 1'b1;
            switch_array = 12'($urandom);
            start_raw = 1'b0;
            cfg_raw   = 1'b0;
            repeat (2 * N) tick();
            start_raw = 1'b1;
            cfg_raw   = 1'b1;
            repeat (N + 4) tick();
            check("busy_no_req", int'(req), 0);
        end
        repeat (busy_len) tick();
        m_busy = 1'b0;
        tick();
        m_txn = (m_txn + 1) % 256;
`ifdef BTN_REQ_AUTOINC_EN
        m_addr = (m_addr + m_burst + 1) % (1 << AW);
`endif
        check("done_req", int'(req), 0);
        check_state("done");
        seen = 1'b0;
        repeat (N + 5) begin
            tick();
            if (req) seen = 1'b1;
        end
        check("idle_no_req", int'(seen), 0);
    endtask

    initial begin
        int guard;
        int op;
        // Power-on reset.
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        check("rst_req", int'(req), 0);
        check("rst_rw", int'(req_rw), 0);
        check_state("rst");

        // Start with no configuration loaded is dropped.
        do_start(1'b1, 1'b0, 0, 1'b0, 0, 1, 1'b0, 0, 0);

        // Configure addr 0x00A, data 0x55 burst 3, then a write with 4-cycle bounce.
        do_cfg(12'h00A, 1'b0);
        check("cfg_step_valid", int'(cfg_valid), 0);
        do_cfg(12'h355, 1'b0);
        check("cfg_addr_0a", int'(req_addr), 'h00A);
        check("cfg_wdata_55", int'(req_wdata), 'h55);
        check("cfg_burst_3", int'(req_burst), 3);
        do_start(1'b1, 1'b0, 0, 1'b0, 1, 3, 1'b0, 5, 4);
        check("txn_one", int'(txn_count), 1);

        // Reset with dirty outputs while a request is pending.
        do_cfg(12'h123, 1'b0);
        do_cfg(12'h9AB, 1'b0);
        mode_switch = 1'b1;
        rw_switch   = 1'b1;
        start_raw   = 1'b0;
        guard = 0;
        while (!req && guard < 100) begin
            tick();
            guard++;
        end
        check("dirty_req", int'(req), 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        start_raw = 1'b1;
        model_reset();
        check("rst2_req", int'(req), 0);
        check("rst2_rw", int'(req_rw), 0);
        check_state("rst2");
        repeat (N + 4) tick();

        // Busy hold-off, then ignored events during BUSY and in mode 1.
        do_cfg(12'h0F0, 1'b0);
        do_cfg(12'h2C3, 1'b0);
        do_start(1'b1, 1'b1, 4, 1'b0, 0, 2, 1'b0, 0, 0);
        do_start(1'b1, 1'b0, 0, 1'b0, 2, 1, 1'b1, 0, 0);
        do_cfg(12'hABC, 1'b1);
        do_start(1'b0, 1'b0, 0, 1'b0, 0, 1, 1'b0, 0, 0);

        // Address advance across the top of the address space.
        do_cfg(12'hFFE, 1'b0);
        do_cfg(12'h311, 1'b0);
        do_start(1'b1, 1'b0, 0, 1'b0, 0, 1, 1'b0, 0, 0);
        do_start(1'b1, 1'b1, 0, 1'b0, 0, 1, 1'b0, 0, 0);
`ifdef BTN_REQ_AUTOINC_EN
        check("autoinc_wrap", int'(req_addr), 'h006);
`else
        check("no_autoinc", int'(req_addr), 'hFFE);
`endif

        // Randomized activity.
        for (int it = 0; it < 30; it++) begin
            op = int'($urandom_range(0, 5));
            case (op)
                0: do_cfg(12'($urandom), 1'b0);
                1: do_cfg(12'($urandom), 1'b1);
                2: do_start(1'b0, 1'($urandom), 0, 1'b0, 0, 1, 1'b0,
                            int'($urandom_range(0, 3)), 0);
                default: do_start(1'b1, 1'($urandom),
                                  ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 5)) : 0,
                                  1'($urandom), int'($urandom_range(0, 4)),
                                  int'($urandom_range(1, 6)), 1'b0,
                                  int'($urandom_range(0, 3)), 0);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/btn_req_frontend.md
# btn_req_frontend

Front-end that turns the board's raw push-buttons and switches into clean bus-master requests. It sits directly upstream of a bus master: debounces active-low buttons, captures address/data/burst from `switch_array` in configuration mode, and issues one request per start press in operation mode. It holds each request under a req/ack handshake and tracks the master's busy flag until the transfer completes.

## Interface
- `DEBOUNCE_CYCLES`, 10: consecutive stable enabled cycles required to accept a button level change (≥2).
- `ADDR_WIDTH`, 12: request address width.
- `DATA_WIDTH`, 8: write data width (≤12).
- `BURST_WIDTH`, 4: burst field width; transfer length = `req_burst`+1.

- `clock` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous and active-low.
- `enable` in 1: global clock enable; 0 freezes all state, outputs hold.
- `start_raw` in 1: raw start button, active-low, asynchronous.
- `cfg_raw` in 1: raw config button, active-low, asynchronous.
- `mode_switch` in 1: 0 = configuration, 1 = operation.
- `rw_switch` in 1: 0 = write, 1 = read; sampled at request launch.
- `switch_array` in 12: configuration value.
- `m_busy` in 1: master busy; high from `req_ack` cycle until transfer done.
- `req_ack` in 1: master accepts request (one-cycle pulse).
- `req` out 1: request valid.
- `req_rw`, `req_addr`, `req_wdata`, `req_burst` out 1/ADDR_WIDTH/DATA_WIDTH/BURST_WIDTH: request fields, stable while `req`=1.
- `cfg_valid` out 1: full configuration (addr + data/burst) loaded.
- `txn_count` out 8: completed transactions, wraps 255→0.

## Operation
- Debouncer (per button): 2-FF synchronizer; counter increments each enabled cycle while synced sample ≠ debounced level, clears when equal; at `DEBOUNCE_CYCLES` flips debounced level and clears. Debounced level resets to 1 (released). Press event = one-cycle pulse on debounced 1→0; release generates nothing.
- Config (only `mode_switch`=0 and FSM IDLE): cfg step register. Step 0 press: `req_addr`←`switch_array[ADDR_WIDTH-1:0]`, step→1, `cfg_valid`←0. Step 1 press: `req_wdata`←`switch_array[DATA_WIDTH-1:0]`, `req_burst`←`switch_array[11:12-BURST_WIDTH]`, step→0, `cfg_valid`←1.
- FSM states IDLE, WAIT_FREE, REQ, BUSY:
  - IDLE: start event with `mode_switch`=1 and `cfg_valid`=1 → REQ if `m_busy`=0, else WAIT_FREE; `req_rw`←`rw_switch` at this edge. Start event otherwise dropped.
  - WAIT_FREE: `m_busy`=0 → REQ.
  - REQ: `req`=1; `req_ack`=1 → BUSY, `req` drops same edge.
  - BUSY: `m_busy`=0 → IDLE, `txn_count`+1 (mod 256).
- Start/cfg events outside IDLE ignored, not queued. `mode_switch` change mid-transaction does not abort.
- `req_ack` outside REQ ignored.
- Reset (any state): FSM IDLE, all outputs 0, cfg step 0, debounce counters 0, debounced levels 1; in-flight request abandoned.

## Timing
- Clean raw falling edge → press pulse `DEBOUNCE_CYCLES`+2 cycles later (enabled cycles) → `req`=1 next cycle (`DEBOUNCE_CYCLES`+3 total, `m_busy`=0).
- Bounce shorter than `DEBOUNCE_CYCLES` cycles produces no event.
- `req` falls on the edge sampling `req_ack`=1; minimum REQ dwell 1 cycle.
- `txn_count` updates on edge leaving BUSY; IDLE accepts a new start event in the following cycle.
- `enable`=0 cycles do not count toward latency.

## Configuration
- `BTN_REQ_AUTOINC_EN` defined: on each BUSY→IDLE, `req_addr` ← `req_addr`+`req_burst`+1, mod 2^ADDR_WIDTH (wraps to 0). Not defined: `req_addr` changes only on config step 0.

## Test plan
- Reset: `rst`=0 one cycle with outputs dirty → all outputs 0, `cfg_valid`=0, `txn_count`=0.
- Debounce: `start_raw` toggling every 4 cycles for 40 cycles, then low (N=10) → no event during bounce; `req` high exactly 13 cycles after final fall.
- Config + write: mode 0, switch 0x00A cfg press, switch 0x355 cfg press, mode 1, rw 0, start → `req`=1 with addr 0x00A, wdata 0x55, burst 3, rw 0; ack → BUSY; `m_busy` low → `txn_count`=1.
- Busy hold-off: `m_busy`=1 at start event → stays WAIT_FREE, `req`=0; `m_busy` low → `req` next cycle.
- Ignored events: start press during BUSY and cfg press in mode 1 → no second request, config unchanged.
- Autoinc (macro on): addr 0xFFE, burst 3, two transactions → second `req_addr`=0x002; macro off → 0xFFE both.
